// File: rtl/bnn_neuron_seq.sv
// Sequential binarised neuron: popcounts CHUNK-wide activation beats against serially loaded weights
// and fires a registered axon once the full vector has been accumulated.

module bnn_neuron_seq_lane (
    input  logic mode,
    input  logic w,
    input  logic x,
    output logic m
);
    assign m = mode ? ~(w ^ x) : (w & x);
endmodule

module bnn_neuron_seq #(
    parameter int INPUTS    = 32,
    parameter int CHUNK     = 8,
    parameter int BIAS_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             setup,
    input  logic             param_in,
    output logic             param_out,
    input  logic             in_valid,
    input  logic [CHUNK-1:0] in_chunk,
    output logic             busy,
    output logic             axon,
    output logic             out_valid
);
    localparam int L     = INPUTS + BIAS_BITS + 1;
    localparam int BEATS = INPUTS / CHUNK;
    localparam int ACC_W = $clog2(INPUTS) + 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;

    state_t                          state, state_n;
    logic [L-1:0]                    chain;
    logic [ACC_W-1:0]                acc, acc_n, pop;
    logic [CNT_W-1:0]                cnt, cnt_n;
    logic                            fire;
    logic                            mode;
    logic [BIAS_BITS-1:0]            bias;
    logic [BEATS-1:0][CHUNK-1:0]     wbeats;
    logic [CHUNK-1:0]                wbeat, match;

    assign mode      = chain[L-1];
    assign bias      = chain[INPUTS +: BIAS_BITS];
    assign wbeats    = chain[INPUTS-1:0];
    assign wbeat     = wbeats[cnt];
    assign param_out = chain[L-1];
    assign busy      = (state == ACCUM);

    for (genvar j = 0; j < CHUNK; j++) begin : g_lane
        bnn_neuron_seq_lane u_lane (
            .mode (mode),
            .w    (wbeat[j]),
            .x    (in_chunk[j]),
            .m    (match[j])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CHUNK; i++) pop = pop + ACC_W'(match[i]);
    end

    // setup outranks in_valid and aborts any partial vector
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (setup) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
        end else if (in_valid) begin
            if (state == IDLE) begin
                acc_n = pop;
                if (BEATS == 1) begin
                    fire  = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n   = CNT_W'(1);
                    state_n = ACCUM;
                end
            end else begin
                acc_n = acc + pop;
                if (cnt == CNT_W'(BEATS - 1)) begin
                    fire    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            chain     <= '0;
            acc       <= '0;
            cnt       <= '0;
            axon      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_valid <= fire;
            if (setup) chain <= {chain[L-2:0], param_in};
            if (fire)  axon  <= (32'(acc_n) > 32'(bias));
        end
    end
endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Directed bench for bnn_neuron_seq: two chained neurons (16 inputs, 8-bit beats, 5-bit bias).

module tb_bnn_neuron_seq;
    logic       clk = 1'b0;
    logic       reset, setup, param_in, in_valid;
    logic [7:0] in_chunk;
    logic       p0, p1, busy0, busy1, axon0, axon1, ov0, ov1;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    bnn_neuron_seq #(.INPUTS(16), .CHUNK(8), .BIAS_BITS(5)) u0 (
        .clk(clk), .reset(reset), .setup(setup), .param_in(param_in), .param_out(p0),
        .in_valid(in_valid), .in_chunk(in_chunk), .busy(busy0), .axon(axon0), .out_valid(ov0)
    );

    bnn_neuron_seq #(.INPUTS(16), .CHUNK(8), .BIAS_BITS(5)) u1 (
        .clk(clk), .reset(reset), .setup(setup), .param_in(p0), .param_out(p1),
        .in_valid(in_valid), .in_chunk(in_chunk), .busy(busy1), .axon(axon1), .out_valid(ov1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits of s, MSB first; optionally check u0.param_out against the bit 22 shifts back
    task automatic shift_cfg(input logic [43:0] s, input int n, input bit chk_out);
        for (int i = 0; i < n; i++) begin
            setup    = 1'b1;
            param_in = s[n-1-i];
            tick();
            if (chk_out && i >= 21) chk($sformatf("chain_out_%0d", i), 32'(p0), 32'(s[n-1-i+21]));
        end
        setup    = 1'b0;
        param_in = 1'b0;
    endtask

    task automatic load(input logic m, input logic [4:0] b, input logic [15:0] w);
        shift_cfg({22'd0, m, b, w}, 22, 1'b0);
    endtask

    task automatic beat(input logic [7:0] c);
        in_valid = 1'b1;
        in_chunk = c;
        tick();
        in_valid = 1'b0;
        in_chunk = 8'h00;
    endtask

    initial begin
        reset = 1'b1; setup = 1'b0; param_in = 1'b1; in_valid = 1'b0; in_chunk = 8'h00;
        for (int i = 0; i < 4; i++) begin
            setup = ~setup;
            tick();
        end
        reset = 1'b0; setup = 1'b0; param_in = 1'b0;
        tick();
        chk("rst_axon", 32'(axon0), 0);
        chk("rst_ov", 32'(ov0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_pout", 32'(p0), 0);

        // AND mode, bias 3, all weights set
        load(1'b0, 5'd3, 16'hFFFF);
        chk("and_pout", 32'(p0), 0);
        beat(8'h0F);
        chk("and_b0_busy", 32'(busy0), 1);
        chk("and_b0_ov", 32'(ov0), 0);
        beat(8'h00);
        chk("and_4_ov", 32'(ov0), 1);
        chk("and_4_axon", 32'(axon0), 1);
        chk("and_4_busy", 32'(busy0), 0);
        tick();
        chk("and_ov_pulse", 32'(ov0), 0);
        chk("and_axon_hold", 32'(axon0), 1);
        beat(8'h07);
        beat(8'h00);
        chk("and_3_ov", 32'(ov0), 1);
        chk("and_3_axon", 32'(axon0), 0);

        // XNOR mode, bias 15, weights 00FF
        load(1'b1, 5'd15, 16'h00FF);
        chk("xnor_pout", 32'(p0), 1);
        beat(8'hFF);
        beat(8'h00);
        chk("xnor_16_ov", 32'(ov0), 1);
        chk("xnor_16_axon", 32'(axon0), 1);
        beat(8'h00);
        beat(8'hFF);
        chk("xnor_0_ov", 32'(ov0), 1);
        chk("xnor_0_axon", 32'(axon0), 0);

        // gap between beats
        beat(8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("gap_busy_%0d", i), 32'(busy0), 1);
            chk($sformatf("gap_ov_%0d", i), 32'(ov0), 0);
        end
        beat(8'h00);
        chk("gap_ov", 32'(ov0), 1);
        chk("gap_axon", 32'(axon0), 1);
        tick();
        chk("gap_ov_once", 32'(ov0), 0);

        // back-to-back vectors: pulses two cycles apart
        beat(8'hFF);
        beat(8'h00);
        chk("b2b_ov1", 32'(ov0), 1);
        chk("b2b_axon1", 32'(axon0), 1);
        beat(8'h00);
        chk("b2b_mid_ov", 32'(ov0), 0);
        chk("b2b_mid_busy", 32'(busy0), 1);
        beat(8'hFF);
        chk("b2b_ov2", 32'(ov0), 1);
        chk("b2b_axon2", 32'(axon0), 0);

        // setup aborts a partial vector; in_valid alongside setup is ignored
        beat(8'hFF);
        setup = 1'b1; param_in = 1'b0; in_valid = 1'b1; in_chunk = 8'h00;
        tick();
        setup = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_ov", 32'(ov0), 0);
        tick();
        chk("abort_ov_late", 32'(ov0), 0);
        chk("abort_axon", 32'(axon0), 0);
        load(1'b1, 5'd15, 16'h00FF);
        beat(8'hFF);
        chk("fresh_b0_ov", 32'(ov0), 0);
        chk("fresh_b0_busy", 32'(busy0), 1);
        beat(8'h00);
        chk("fresh_ov", 32'(ov0), 1);
        chk("fresh_axon", 32'(axon0), 1);

        // daisy chain: first 22 bits land in u1, last 22 in u0
        shift_cfg({1'b0, 5'd0, 16'h0001, 1'b1, 5'd15, 16'hFFFF}, 44, 1'b1);
        chk("chain_p0_mode", 32'(p0), 1);
        chk("chain_p1_mode", 32'(p1), 0);
        beat(8'hFF);
        beat(8'hFF);
        chk("chain_v1_ov", 32'({ov1, ov0}), 32'h3);
        chk("chain_v1_axon", 32'({axon1, axon0}), 32'h3);
        beat(8'h01);
        beat(8'h00);
        chk("chain_v2_axon", 32'({axon1, axon0}), 32'h2);
        beat(8'hFE);
        beat(8'hFF);
        chk("chain_v3_axon", 32'({axon1, axon0}), 32'h0);

        // reset mid-vector gives no pulse
        beat(8'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_ov", 32'(ov0), 0);
        chk("rst_mid_busy", 32'(busy0), 0);
        chk("rst_mid_axon", 32'(axon0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
